// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray/binary conversion, popcount and saturation helpers for gray2bin_n
package gray_pkg;

  localparam int GW_MAX = 32;
  typedef logic [GW_MAX-1:0] gword_t;

  // Callers zero-extend narrower codes; zero upper bits leave the lower decode unaffected.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b = g;
    for (int i = GW_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [5:0] popcount(input gword_t x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < GW_MAX; i++) begin
      c = c + 6'(x[i]);
    end
    return c;
  endfunction

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/gray_step_chk.sv
// rtl/gray_step_chk.sv - Gray single-step checker with sticky flag and saturating counter
// Optional backward-step check on decoded values under GRAY2BIN_STEP_DIR_EN.
module gray_step_chk
  import gray_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     gray_in,
  input  logic             v1,
  input  logic [N-1:0]     bin,
  input  logic             err_clr,
  output logic             step_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [N-1:0] prev_gray;
  logic         prev_vld;
  logic         e1;
  logic         hd_err;
  logic         dir_err;
  logic         err_next;

  assign hd_err = prev_vld && (popcount(gword_t'(gray_in ^ prev_gray)) > 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
      prev_vld  <= 1'b0;
      e1        <= 1'b0;
    end else if (in_valid) begin
      prev_gray <= gray_in;
      prev_vld  <= 1'b1;
      e1        <= hd_err;
    end
  end

`ifdef GRAY2BIN_STEP_DIR_EN
  logic [N-1:0] prev_bin;
  logic         prev_bin_vld;

  // A Hamming-1 change can still be a backward step; only hold or +1 is allowed.
  assign dir_err = v1 && prev_bin_vld && (bin != prev_bin) && (bin != prev_bin + N'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bin     <= '0;
      prev_bin_vld <= 1'b0;
    end else if (v1) begin
      prev_bin     <= bin;
      prev_bin_vld <= 1'b1;
    end
  end
`else
  logic unused_bin;
  assign unused_bin = ^bin;
  assign dir_err    = 1'b0;
`endif

  assign err_next = (v1 & e1) | dir_err;

  // An error in the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      step_err <= err_next;
      if (err_next) begin
        err_sticky <= 1'b1;
        if (err_clr) begin
          err_cnt <= CNT_W'(1);
        end else if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/gray2bin_n.sv
// rtl/gray2bin_n.sv - Two-stage Gray-to-binary decoder with step checking
// Optional macro: GRAY2BIN_STEP_DIR_EN (adds backward-step detection).
module gray2bin_n
  import gray_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N-1:0]     gray_in,
  output logic             out_valid,
  output logic [N-1:0]     bin_out,
  output logic             step_err,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic [N-1:0] g1;
  logic         v1;
  logic [N-1:0] bin_c;

  assign bin_c = N'(gray2bin(gword_t'(g1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1        <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid) begin
        g1 <= gray_in;
      end
      if (v1) begin
        bin_out <= bin_c;
      end
    end
  end

  gray_step_chk #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_step_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .gray_in    (gray_in),
    .v1         (v1),
    .bin        (bin_c),
    .err_clr    (err_clr),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_gray2bin_n.sv
// tb/tb_gray2bin_n.sv - Self-checking bench for gray2bin_n (N=4, CNT_W=2)
module tb_gray2bin_n;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [N-1:0]     gray_in = '0;
  logic             out_valid;
  logic [N-1:0]     bin_out;
  logic             step_err;
  logic             err_sticky;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  gray2bin_n #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .gray_in    (gray_in),
    .out_valid  (out_valid),
    .bin_out    (bin_out),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [3:0] b;
    logic       e;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [3:0] m_pg;
  logic       m_pv;
  logic [3:0] m_pb;
  logic       m_pbv;
  logic       m_sticky;
  int         m_cnt;
  logic       clr_at_edge = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int i);
    logic [3:0] b;
    b = 4'(i);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic model_reset();
    m_pg = '0; m_pv = 1'b0; m_pb = '0; m_pbv = 1'b0;
    m_sticky = 1'b0; m_cnt = 0;
  endtask

  task automatic send(input logic [3:0] g, input logic [3:0] eb, input logic ee);
    exp_t e;
    e.bin = eb;
    e.err = ee;
    sb.push_back(e);
    m_pg = g; m_pv = 1'b1; m_pb = eb; m_pbv = 1'b1;
    in_valid = 1'b1;
    gray_in  = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_auto(input logic [3:0] g);
    logic [3:0] eb;
    logic       ee;
    eb = g2b(g);
    ee = m_pv && ($countones(g ^ m_pg) > 1);
`ifdef GRAY2BIN_STEP_DIR_EN
    if (m_pbv && eb != m_pb && eb != 4'(m_pb + 4'd1)) ee = 1'b1;
`endif
    send(g, eb, ee);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) clr_at_edge <= err_clr;

  // Scoreboard: pops one expectation per out_valid and tracks sticky/count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bin_out", int'(bin_out), int'(e.bin));
          chk("step_err", int'(step_err), int'(e.err));
          if (e.err) begin
            m_sticky = 1'b1;
            if (clr_at_edge) m_cnt = 1;
            else if (m_cnt < 3) m_cnt++;
          end else if (clr_at_edge) begin
            m_sticky = 1'b0;
            m_cnt = 0;
          end
        end
      end else if (clr_at_edge) begin
        m_sticky = 1'b0;
        m_cnt = 0;
      end
      if (out_valid || clr_at_edge) begin
        chk("err_sticky", int'(err_sticky), int'(m_sticky));
        chk("err_cnt", int'(err_cnt), m_cnt);
      end
    end
  end

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4'b0000, 4'd0, 1'b0};
    tbl[1] = '{4'b0001, 4'd1, 1'b0};
    tbl[2] = '{4'b0011, 4'd2, 1'b0};
    tbl[3] = '{4'b0010, 4'd3, 1'b0};
    tbl[4] = '{4'b0110, 4'd4, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_step_err", int'(step_err), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 5; i++) send(tbl[i].g, tbl[i].b, tbl[i].e);
    idle(3);

    // Walk all 16 codes, including the 1000 -> 0000 wrap.
    for (int i = 4; i <= 20; i++) send_auto(b2g(i % 16));
    idle(3);
    chk("wrap_sticky", int'(err_sticky), 0);

    pulse_reset();
    send(4'b0000, 4'd0, 1'b0);
    send(4'b0011, 4'd2, 1'b1);
    idle(3);
    chk("viol_sticky", int'(err_sticky), 1);
    chk("viol_cnt", int'(err_cnt), 1);

    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(1);
    chk("clr_cnt", int'(err_cnt), 0);
    send_auto(4'b0000);
    send_auto(4'b0011);
    send_auto(4'b0000);
    send_auto(4'b0011);
    send_auto(4'b0000);
    idle(3);
    chk("sat_cnt", int'(err_cnt), 3);
    send_auto(4'b0011);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(3);
    chk("clr_vs_err_cnt", int'(err_cnt), 1);
    chk("clr_vs_err_sticky", int'(err_sticky), 1);

    send(4'b0011, 4'd2, 1'b0);
    send(4'b0011, 4'd2, 1'b0);
    idle(1);
    chk("hold_bin0", int'(bin_out), 2);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      chk("hold_bin", int'(bin_out), 2);
      chk("hold_no_valid", int'(out_valid), 0);
    end
    send(4'b0010, 4'd3, 1'b0);
    idle(3);
    chk("after_hold_bin", int'(bin_out), 3);

    pulse_reset();
    send(4'b0011, 4'd2, 1'b0);
`ifdef GRAY2BIN_STEP_DIR_EN
    send(4'b0001, 4'd1, 1'b1);
`else
    send(4'b0001, 4'd1, 1'b0);
`endif
    idle(3);

    send_auto(4'b0101);
    send_auto(4'b0100);
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", int'(out_valid), 0);
      idle(1);
    end
    chk("flush_sticky", int'(err_sticky), 0);
    chk("flush_cnt", int'(err_cnt), 0);
    send(4'b0110, 4'd4, 1'b0);
    idle(4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
